expr_gen: RTL and testbench

EXPR_GEN -- requirements
Module: expr_gen

---
 rtl/expr_pkg.sv | 16 +
 rtl/expr_char_enc.sv | 15 +
 rtl/expr_gen.sv | 118 +++++++++++
 tb/tb_expr_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared constants for the expression generator: ASCII codes, FSM state
// encoding and the default operand capacity.
package expr_pkg;

    localparam int DEF_MAX_OPERANDS = 8;

    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_MUL  = 8'h2A;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DIGIT = 2'd1;
    localparam logic [1:0] ST_OP    = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

endpackage

// File: rtl/expr_char_enc.sv
// Combinational character encoder: a BCD digit becomes '0'..'9', an
// operator bit becomes '+' (0) or '*' (1).
module expr_char_enc
    import expr_pkg::*;
(
    input  logic       sel_op,
    input  logic [3:0] digit,
    input  logic       op_bit,
    output logic [7:0] ascii
);

    assign ascii = sel_op ? (op_bit ? CH_MUL : CH_PLUS)
                          : (CH_ZERO + {4'h0, digit});

endmodule

// File: rtl/expr_gen.sv
// Streams a captured "digit (op digit)*" expression as ASCII characters over
// a valid/ready output, one character per accepted transfer.
module expr_gen
    import expr_pkg::*;
#(
    parameter int MAX_OPERANDS = DEF_MAX_OPERANDS
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      start,
    input  logic [3:0]                num_cnt,
    input  logic [4*MAX_OPERANDS-1:0] digits,
    input  logic [MAX_OPERANDS-2:0]   ops,
    input  logic                      out_ready,
    output logic [7:0]                out_char,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                o_state
);

    // Handshake: a character moves on any cycle where out_valid and
    // out_ready are both high; while out_valid is high and out_ready is low
    // the FSM does not advance, so out_char/out_valid hold their values.

    localparam logic [3:0] MAX_N = 4'(MAX_OPERANDS);

    logic [1:0]                r_state;
    logic [4*MAX_OPERANDS-1:0] r_digits;
    logic [MAX_OPERANDS-2:0]   r_ops;
    logic [3:0]                r_num;
    logic [3:0]                r_idx;
    logic                      r_err;

    logic       w_req_ok;
    logic       w_last;
    logic       w_xfer;
    logic       w_sel_op;
    logic [3:0] w_digit;
    logic       w_op_bit;
    logic [7:0] w_ascii;

    // Only operands below num_cnt are range-checked; unused slots are don't-care.
    always_comb begin
        w_req_ok = (num_cnt != 4'd0) && (num_cnt <= MAX_N);
        for (int k = 0; k < MAX_OPERANDS; k++) begin
            if ((4'(k) < num_cnt) && (digits[4*k +: 4] > 4'd9)) begin
                w_req_ok = 1'b0;
            end
        end
    end

    assign w_sel_op = (r_state == ST_OP);
    assign w_digit  = 4'(r_digits >> {r_idx, 2'b00});
    assign w_op_bit = 1'(r_ops >> r_idx);
    assign w_last   = (r_idx == (r_num - 4'd1));
    assign w_xfer   = out_valid && out_ready;

    expr_char_enc u_enc (
        .sel_op (w_sel_op),
        .digit  (w_digit),
        .op_bit (w_op_bit),
        .ascii  (w_ascii)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= ST_IDLE;
            r_digits <= '0;
            r_ops    <= '0;
            r_num    <= 4'd0;
            r_idx    <= 4'd0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_req_ok) begin
                            r_digits <= digits;
                            r_ops    <= ops;
                            r_num    <= num_cnt;
                            r_idx    <= 4'd0;
                            r_state  <= ST_DIGIT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_DIGIT: begin
                    if (w_xfer) begin
                        r_state <= w_last ? ST_FIN : ST_OP;
                    end
                end
                ST_OP: begin
                    if (w_xfer) begin
                        r_idx   <= r_idx + 4'd1;
                        r_state <= ST_DIGIT;
                    end
                end
                ST_FIN: begin
                    r_idx   <= 4'd0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == ST_DIGIT) || (r_state == ST_OP);
    assign out_char  = out_valid ? w_ascii : 8'h00;
    assign busy      = out_valid;
    assign done      = (r_state == ST_FIN);
    assign err       = r_err;
    assign o_state   = r_state;

endmodule

// File: tb/tb_expr_gen.sv
// Bench for expr_gen: table vectors, hand-written stall/clear sequences and
// randomized requests against a string-level reference model.
module tb_expr_gen;
    import expr_pkg::*;

    localparam int MAXN = 8;

    logic              clk = 1'b0;
    logic              clr = 1'b1;
    logic              start = 1'b0;
    logic [3:0]        num_cnt = 4'd0;
    logic [4*MAXN-1:0] digits = '0;
    logic [MAXN-2:0]   ops = '0;
    logic              out_ready = 1'b0;
    logic [7:0]        out_char;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        o_state;

    expr_gen #(.MAX_OPERANDS(MAXN)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .num_cnt   (num_cnt),
        .digits    (digits),
        .ops       (ops),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .o_state   (o_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard
    logic [7:0] exp_q[$];
    logic [7:0] rx_str[$];
    int         xfer_cyc[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         err_cnt  = 0;
    bit         stall_prev = 1'b0;
    logic [7:0] held_char = 8'h00;

    always @(negedge clk) begin
        if (stall_prev) begin
            check("stall_valid_hold", {31'd0, out_valid}, 32'd1);
            check("stall_char_hold", {24'd0, out_char}, {24'd0, held_char});
        end
        if (out_valid) check("busy_with_valid", {31'd0, busy}, 32'd1);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_char", {24'd0, out_char}, 32'hFFFF_FFFF);
            end else begin
                check("char", {24'd0, out_char}, {24'd0, exp_q.pop_front()});
            end
            rx_str.push_back(out_char);
            xfer_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_low_at_done", {31'd0, busy}, 32'd0);
        end
        if (err) err_cnt++;
        stall_prev = out_valid && !out_ready;
        held_char  = out_char;
    end

    // Reference model: expected string from the request, and request validity.
    function automatic bit req_ok(input logic [3:0] n, input logic [31:0] d);
        if (n == 0 || n > MAXN) return 1'b0;
        for (int k = 0; k < n; k++) if (d[4*k +: 4] > 9) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_fill(input logic [3:0] n, input logic [31:0] d, input logic [6:0] o);
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(8'(48 + d[4*k +: 4]));
            if (k < n - 1) exp_q.push_back(o[k] ? 8'h2A : 8'h2B);
        end
    endtask

    // Digit/'+'/'*' recognizer over a received string.
    function automatic bit recognize(input logic [7:0] s[$]);
        if (s.size() % 2 == 0) return 1'b0;
        for (int i = 0; i < s.size(); i++) begin
            if (i % 2 == 0) begin
                if (s[i] < 8'h30 || s[i] > 8'h39) return 1'b0;
            end else if (s[i] != 8'h2A && s[i] != 8'h2B) begin
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    // ready_mode: 0 = always 1, 1 = random, 2 = pattern 1,0,0,1,1 then 1
    task automatic run_expr(input logic [3:0] n, input logic [31:0] d, input logic [6:0] o,
                            input int ready_mode);
        bit ok;
        int s_cyc;
        bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ok = req_ok(n, d);
        if (ok) model_fill(n, d, o); else exp_q.delete();
        rx_str.delete();
        xfer_cyc.delete();
        done_cnt = 0;
        err_cnt  = 0;
        start    = 1'b1;
        num_cnt  = n;
        digits   = d;
        ops      = o;
        out_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        s_cyc   = cyc;
        start   = 1'b0;
        digits  = $urandom;
        ops     = 7'($urandom);
        num_cnt = 4'($urandom);
        if (!ok) begin
            check("err_busy_low", {31'd0, busy}, 32'd0);
            check("err_no_valid", {31'd0, out_valid}, 32'd0);
            repeat (3) @(posedge clk);
            #1;
            check("err_pulse_count", err_cnt, 1);
            check("err_no_chars", rx_str.size(), 0);
            check("err_no_done", done_cnt, 0);
        end else begin
            for (int i = 0; i < 300 && done_cnt == 0; i++) begin
                if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
                else if (ready_mode == 2) out_ready = (i < 5) ? pat[i] : 1'b1;
                else out_ready = 1'b1;
                @(posedge clk); #1;
            end
            check("done_seen", done_cnt, 1);
            check("all_chars_delivered", exp_q.size(), 0);
            check("string_len", rx_str.size(), 2 * n - 1);
            check("recognizer_out", {31'd0, recognize(rx_str)}, 32'd1);
            check("no_err_on_valid", err_cnt, 0);
            if (ready_mode == 0) begin
                for (int i = 0; i < xfer_cyc.size(); i++)
                    check("b2b_cycle", xfer_cyc[i], s_cyc + i);
                check("done_cycle", done_cyc, s_cyc + 2 * n - 1);
            end
            @(posedge clk); #1;
            check("done_single_pulse", done_cnt, 1);
            check("idle_after_done", {30'd0, o_state}, {30'd0, ST_IDLE});
        end
        out_ready = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  n;
        logic [31:0] d;
        logic [6:0]  o;
        int          mode;
        bit          exp_err;
        int          exp_len;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'd3, 32'h0000_0321, 7'b0000010, 0, 1'b0, 5};  // "1+2*3"
        vecs[1] = '{4'd1, 32'h0000_0007, 7'b0000000, 0, 1'b0, 1};  // "7"
        vecs[2] = '{4'd0, 32'h0000_0011, 7'b0000000, 0, 1'b1, 0};
        vecs[3] = '{4'd9, 32'h1111_1111, 7'b0000000, 0, 1'b1, 0};
        vecs[4] = '{4'd2, 32'h0000_00A5, 7'b0000000, 0, 1'b1, 0};  // operand 1 = A
        vecs[5] = '{4'd8, 32'h9999_9999, 7'b1111111, 0, 1'b0, 15};
        vecs[6] = '{4'd2, 32'hF000_0012, 7'b0000001, 1, 1'b0, 3};  // unused F ignored
        vecs[7] = '{4'd5, 32'h0009_8765, 7'b0101010, 1, 1'b0, 9};

        // Clock/reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_char", {24'd0, out_char}, 32'h0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_state", {30'd0, o_state}, {30'd0, ST_IDLE});
        clr = 1'b0;

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            check("vec_model_err", {31'd0, !req_ok(vecs[i].n, vecs[i].d)}, {31'd0, vecs[i].exp_err});
            run_expr(vecs[i].n, vecs[i].d, vecs[i].o, vecs[i].mode);
            if (!vecs[i].exp_err) check("vec_len", rx_str.size(), vecs[i].exp_len);
        end

        // Stall pattern on "9+0"
        run_expr(4'd2, 32'h0000_0009, 7'b0, 2);
        check("stall_c0", {24'd0, rx_str[0]}, 32'h39);
        check("stall_c1", {24'd0, rx_str[1]}, 32'h2B);
        check("stall_c2", {24'd0, rx_str[2]}, 32'h30);

        // Clear after second character of a 5-operand expression
        model_fill(4'd5, 32'h0005_4321, 7'b0);
        rx_str.delete();
        done_cnt  = 0;
        out_ready = 1'b1;
        start     = 1'b1;
        num_cnt   = 4'd5;
        digits    = 32'h0005_4321;
        ops       = 7'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        check("clr_char", {24'd0, out_char}, 32'h0);
        check("clr_valid", {31'd0, out_valid}, 32'd0);
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_done", {31'd0, done}, 32'd0);
        check("clr_err", {31'd0, err}, 32'd0);
        check("clr_chars_before", rx_str.size(), 2);
        exp_q.delete();
        clr = 1'b0;
        run_expr(4'd5, 32'h0005_4321, 7'b0001111, 0);

        // Randomized requests
        for (int t = 0; t < 40; t++) begin
            logic [3:0]  rn;
            logic [31:0] rd;
            rn = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, MAXN));
            for (int k = 0; k < MAXN; k++)
                rd[4*k +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                                             : 4'($urandom_range(0, 9));
            run_expr(rn, rd, 7'($urandom), $urandom_range(0, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
